// File: rtl/rx_drop_stat_sched.sv
// Per-port frame/drop event accumulator for RX MAC Lite buffers.
// Round-robin schedules saturating per-port reports onto one valid/ready output.
module rx_drop_stat_sched #(
    parameter int unsigned PORTS   = 2,
    parameter int unsigned REGIONS = 4,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned PW     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [PORTS*REGIONS-1:0]   i_evt_eof,
    input  logic [PORTS*REGIONS-1:0]   i_evt_drop,
    input  logic                       i_flush,
    output logic [PW-1:0]              o_out_port,
    output logic [CNT_W-1:0]           o_out_frames,
    output logic [CNT_W-1:0]           o_out_drops,
    output logic                       o_out_ovf,
    output logic                       o_out_src_rdy,
    input  logic                       i_out_dst_rdy
);

    logic [CNT_W-1:0] r_acc_f [PORTS];
    logic [CNT_W-1:0] r_acc_d [PORTS];
    logic [PORTS-1:0] r_ovf;
    logic [PW-1:0]    r_rr_ptr;
    logic [PW-1:0]    r_out_port;
    logic [CNT_W-1:0] r_out_frames;
    logic [CNT_W-1:0] r_out_drops;
    logic             r_out_ovf;
    logic             r_out_src_rdy;

    logic [CNT_W-1:0] w_inc_f [PORTS];
    logic [CNT_W-1:0] w_inc_d [PORTS];
    logic [CNT_W:0]   w_sum_f [PORTS];
    logic [CNT_W:0]   w_sum_d [PORTS];
    logic [CNT_W-1:0] w_nxt_f [PORTS];
    logic [CNT_W-1:0] w_nxt_d [PORTS];
    logic [PORTS-1:0] w_sat;
    logic [PORTS-1:0] w_nz;
    logic             w_found;
    logic [PW-1:0]    w_gnt;
    logic             w_load;
    logic             w_grant;

    always_comb begin
        for (int unsigned p = 0; p < PORTS; p++) begin
            w_inc_f[p] = '0;
            w_inc_d[p] = '0;
            for (int unsigned r = 0; r < REGIONS; r++) begin
                w_inc_f[p] = w_inc_f[p] + CNT_W'(i_evt_eof[p*REGIONS+r]);
                w_inc_d[p] = w_inc_d[p]
                             + CNT_W'(i_evt_eof[p*REGIONS+r] & i_evt_drop[p*REGIONS+r]);
            end
        end
    end

    // Carry out of the widened sum marks lost counts: clip and flag overflow.
    always_comb begin
        for (int unsigned p = 0; p < PORTS; p++) begin
            w_sum_f[p] = {1'b0, r_acc_f[p]} + {1'b0, w_inc_f[p]};
            w_sum_d[p] = {1'b0, r_acc_d[p]} + {1'b0, w_inc_d[p]};
            w_nxt_f[p] = w_sum_f[p][CNT_W] ? '1 : w_sum_f[p][CNT_W-1:0];
            w_nxt_d[p] = w_sum_d[p][CNT_W] ? '1 : w_sum_d[p][CNT_W-1:0];
            w_sat[p]   = w_sum_f[p][CNT_W] | w_sum_d[p][CNT_W];
            w_nz[p]    = |r_acc_f[p];
        end
    end

    // Search order is rr_ptr+1, rr_ptr+2, ... wrapping back to rr_ptr itself last.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int unsigned i = 1; i <= PORTS; i++) begin
            for (int unsigned q = 0; q < PORTS; q++) begin
                if (!w_found && w_nz[q] && (q == (32'(r_rr_ptr) + i) % PORTS)) begin
                    w_found = 1'b1;
                    w_gnt   = PW'(q);
                end
            end
        end
    end

    assign w_load  = ~r_out_src_rdy | i_out_dst_rdy;
    assign w_grant = w_load & w_found & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                r_acc_f[p] <= '0;
                r_acc_d[p] <= '0;
            end
            r_ovf         <= '0;
            r_rr_ptr      <= '0;
            r_out_port    <= '0;
            r_out_frames  <= '0;
            r_out_drops   <= '0;
            r_out_ovf     <= 1'b0;
            r_out_src_rdy <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (i_flush) begin
                    r_acc_f[p] <= '0;
                    r_acc_d[p] <= '0;
                    r_ovf[p]   <= 1'b0;
                end else if (w_grant && (w_gnt == PW'(p))) begin
                    // Snapshot leaves; this cycle's events start the next interval.
                    r_acc_f[p] <= w_inc_f[p];
                    r_acc_d[p] <= w_inc_d[p];
                    r_ovf[p]   <= 1'b0;
                end else begin
                    r_acc_f[p] <= w_nxt_f[p];
                    r_acc_d[p] <= w_nxt_d[p];
                    r_ovf[p]   <= r_ovf[p] | w_sat[p];
                end
            end
            if (w_load) begin
                r_out_src_rdy <= w_grant;
                if (w_grant) begin
                    r_out_port   <= w_gnt;
                    r_out_frames <= r_acc_f[w_gnt];
                    r_out_drops  <= r_acc_d[w_gnt];
                    r_out_ovf    <= r_ovf[w_gnt];
                    r_rr_ptr     <= w_gnt;
                end
            end
        end
    end

    assign o_out_port    = r_out_port;
    assign o_out_frames  = r_out_frames;
    assign o_out_drops   = r_out_drops;
    assign o_out_ovf     = r_out_ovf;
    assign o_out_src_rdy = r_out_src_rdy;

endmodule

// File: tb/tb_rx_drop_stat_sched.sv
// Bench for rx_drop_stat_sched: a 16-bit and a 4-bit instance share stimulus and are
// checked every cycle against an unbounded-count model, plus hand-computed expectations.
module tb_rx_drop_stat_sched;

    localparam int unsigned PORTS   = 2;
    localparam int unsigned REGIONS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [PORTS*REGIONS-1:0] eof, drop;
    logic flush, dst;

    logic [0:0]  port_a, port_b;
    logic [15:0] fr_a, dr_a;
    logic [3:0]  fr_b, dr_b;
    logic        ovf_a, ovf_b, rdy_a, rdy_b;

    rx_drop_stat_sched #(.PORTS(PORTS), .REGIONS(REGIONS), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_evt_eof(eof), .i_evt_drop(drop), .i_flush(flush),
        .o_out_port(port_a), .o_out_frames(fr_a), .o_out_drops(dr_a), .o_out_ovf(ovf_a),
        .o_out_src_rdy(rdy_a), .i_out_dst_rdy(dst)
    );

    rx_drop_stat_sched #(.PORTS(PORTS), .REGIONS(REGIONS), .CNT_W(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_evt_eof(eof), .i_evt_drop(drop), .i_flush(flush),
        .o_out_port(port_b), .o_out_frames(fr_b), .o_out_drops(dr_b), .o_out_ovf(ovf_b),
        .o_out_src_rdy(rdy_b), .i_out_dst_rdy(dst)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: true event counts since each port's last report; reported values are clipped.
    function automatic int cap(int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    int tf [2][PORTS];
    int td [2][PORTS];
    bit m_vld [2];
    int m_port [2];
    int m_f [2];
    int m_d [2];
    bit m_ovf [2];
    int m_rr [2];

    always @(posedge clk or negedge rst_n) begin : model
        int g;
        bit take;
        int ef, ed, q;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < PORTS; p++) begin
                    tf[k][p] = 0;
                    td[k][p] = 0;
                end
                m_vld[k] = 0; m_port[k] = 0; m_f[k] = 0; m_d[k] = 0; m_ovf[k] = 0;
                m_rr[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                take = !m_vld[k] || dst;
                g = -1;
                if (take && !flush) begin
                    for (int i = 1; i <= PORTS; i++) begin
                        q = (m_rr[k] + i) % PORTS;
                        if (g < 0 && tf[k][q] > 0) g = q;
                    end
                end
                if (take) begin
                    if (g >= 0) begin
                        m_vld[k]  = 1;
                        m_port[k] = g;
                        m_f[k]    = (tf[k][g] > cap(k)) ? cap(k) : tf[k][g];
                        m_d[k]    = (td[k][g] > cap(k)) ? cap(k) : td[k][g];
                        m_ovf[k]  = (tf[k][g] > cap(k)) || (td[k][g] > cap(k));
                        m_rr[k]   = g;
                    end else begin
                        m_vld[k] = 0;
                    end
                end
                for (int p = 0; p < PORTS; p++) begin
                    ef = $countones(eof[p*REGIONS +: REGIONS]);
                    ed = $countones(eof[p*REGIONS +: REGIONS] & drop[p*REGIONS +: REGIONS]);
                    if (flush) begin
                        tf[k][p] = 0;
                        td[k][p] = 0;
                    end else if (p == g) begin
                        tf[k][p] = ef;
                        td[k][p] = ed;
                    end else begin
                        tf[k][p] += ef;
                        td[k][p] += ed;
                    end
                end
            end
        end
    end

    task automatic cmp(int k, int rdy, int port, int f, int d, int ovf);
        chk($sformatf("model%0d_src_rdy", k), rdy, int'(m_vld[k]));
        if (m_vld[k]) begin
            chk($sformatf("model%0d_port", k), port, m_port[k]);
            chk($sformatf("model%0d_frames", k), f, m_f[k]);
            chk($sformatf("model%0d_drops", k), d, m_d[k]);
            chk($sformatf("model%0d_ovf", k), ovf, int'(m_ovf[k]));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp(0, int'(rdy_a), int'(port_a), int'(fr_a), int'(dr_a), int'(ovf_a));
            cmp(1, int'(rdy_b), int'(port_b), int'(fr_b), int'(dr_b), int'(ovf_b));
        end
    end

    task automatic idle(int n);
        eof = '0; drop = '0; flush = 1'b0; dst = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int sum;

    initial begin
        eof = '0; drop = '0; flush = 1'b0; dst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_src_rdy", int'(rdy_a), 0);
        chk("reset_frames", int'(fr_a), 0);
        chk("reset_port", int'(port_a), 0);
        rst_n = 1'b1;

        // Single drop on port0 region1
        @(negedge clk); eof = 8'h02; drop = 8'h02;
        @(negedge clk); eof = '0; drop = '0;
        chk("t1_not_yet", int'(rdy_a), 0);
        @(negedge clk);
        chk("t1_rdy", int'(rdy_a), 1);
        chk("t1_port", int'(port_a), 0);
        chk("t1_frames", int'(fr_a), 1);
        chk("t1_drops", int'(dr_a), 1);
        chk("t1_ovf", int'(ovf_a), 0);
        @(negedge clk);
        chk("t1_idle", int'(rdy_a), 0);

        // Fairness: one EOF per port per cycle for 12 cycles
        idle(2);
        eof = 8'h11; sum = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (rdy_a) sum += int'(fr_a);
            if (j >= 3) begin
                chk("t2_port", int'(port_a), (j % 2 == 1) ? 0 : 1);
                chk("t2_frames", int'(fr_a), 2);
            end
        end
        eof = '0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (rdy_a) sum += int'(fr_a);
        end
        chk("t2_sum", sum, 24);

        // Backpressure: port1 4 EOF/cycle for 10 cycles with the output held
        idle(3);
        dst = 1'b0; eof = 8'hF0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 1) chk("t3_first", int'(rdy_a), 0);
            else begin
                chk("t3_hold_rdy", int'(rdy_a), 1);
                chk("t3_hold_port", int'(port_a), 1);
                chk("t3_hold_frames", int'(fr_a), 4);
            end
        end
        eof = '0; dst = 1'b1;
        @(negedge clk);
        chk("t3_rdy", int'(rdy_a), 1);
        chk("t3_port", int'(port_a), 1);
        chk("t3_frames", int'(fr_a), 36);
        chk("t3_frames_narrow", int'(fr_b), 15);
        chk("t3_ovf_narrow", int'(ovf_b), 1);

        // Saturation on the 4-bit instance
        idle(3);
        dst = 1'b0; eof = 8'h0F; drop = 8'h0F;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                chk("t4_pend_port", int'(port_b), 0);
                chk("t4_pend_frames", int'(fr_b), 4);
            end
            if (j == 5) begin eof = '0; drop = '0; end
        end
        @(negedge clk);
        chk("t4_pend_drops", int'(dr_b), 4);
        dst = 1'b1;
        @(negedge clk);
        chk("t4_sat_frames", int'(fr_b), 15);
        chk("t4_sat_drops", int'(dr_b), 15);
        chk("t4_sat_ovf", int'(ovf_b), 1);
        chk("t4_wide_frames", int'(fr_a), 16);
        chk("t4_wide_ovf", int'(ovf_a), 0);
        eof = 8'h01;
        @(negedge clk); eof = '0;
        chk("t4_gap", int'(rdy_b), 0);
        @(negedge clk);
        chk("t4_next_rdy", int'(rdy_b), 1);
        chk("t4_next_frames", int'(fr_b), 1);
        chk("t4_next_ovf", int'(ovf_b), 0);

        // Events arriving in the grant cycle
        idle(3);
        eof = 8'h01;
        @(negedge clk); eof = 8'h07;
        @(negedge clk); eof = '0;
        chk("t5_first", int'(fr_a), 1);
        @(negedge clk);
        chk("t5_port", int'(port_a), 0);
        chk("t5_frames", int'(fr_a), 3);
        @(negedge clk);
        chk("t5_idle", int'(rdy_a), 0);

        // FLUSH with a pending report
        idle(2);
        dst = 1'b0; eof = 8'h11;
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        chk("t6_pend_port", int'(port_a), 1);
        chk("t6_pend_frames", int'(fr_a), 1);
        @(negedge clk); flush = 1'b0; eof = '0; dst = 1'b1;
        chk("t6_held_rdy", int'(rdy_a), 1);
        chk("t6_held_frames", int'(fr_a), 1);
        @(negedge clk);
        chk("t6_flushed", int'(rdy_a), 0);
        @(negedge clk);
        chk("t6_flushed2", int'(rdy_a), 0);

        // Async reset while a report is pending
        eof = 8'h11; dst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t6_pre_reset", int'(rdy_a), 1);
        #2 rst_n = 1'b0; eof = '0;
        #1;
        chk("t6_async_rdy", int'(rdy_a), 0);
        chk("t6_async_rdy_narrow", int'(rdy_b), 0);
        @(negedge clk); rst_n = 1'b1; eof = 8'h11; dst = 1'b1;
        @(negedge clk); eof = '0;
        chk("t6_post_idle", int'(rdy_a), 0);
        @(negedge clk);
        chk("t6_rr_first", int'(port_a), 1);
        chk("t6_rr_first_frames", int'(fr_a), 1);
        @(negedge clk);
        chk("t6_rr_second", int'(port_a), 0);
        chk("t6_rr_second_frames", int'(fr_a), 1);

        idle(3);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
